// File: rtl/spi_cont_pkg.sv
// Shared types and defaults for the spi_cont SPI master byte controller.
package spi_cont_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_cont_if.sv
// Command-bus side of spi_cont: write request/ready and read-back strobe/data.
interface spi_cont_if #(
    parameter int DATA_WIDTH = spi_cont_pkg::DEF_DATA_WIDTH
);
    logic                  wr_stb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_stb;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_stb, wr_data,
        input  wr_ready, rd_stb, rd_data
    );

    modport slave (
        input  wr_stb, wr_data,
        output wr_ready, rd_stb, rd_data
    );
endinterface

// File: rtl/spi_cont_shifter.sv
// Parallel-load transmit shift register and serial-in receive shift register.
module spi_cont_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_shift,
    input  logic                  i_sample,
    input  logic                  i_miso,
    output logic                  o_tx_msb,
    output logic [DATA_WIDTH-1:0] o_rx_data
);

    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (i_load) begin
            r_tx <= i_load_data;
            r_rx <= '0;
        end else begin
            if (i_shift)
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            if (i_sample)
                r_rx <= {r_rx[DATA_WIDTH-2:0], i_miso};
        end
    end

    assign o_tx_msb  = r_tx[DATA_WIDTH-1];
    assign o_rx_data = r_rx;

endmodule

// File: rtl/spi_cont.sv
// SPI mode-0 master, MSB first, paced by an external half-bit TICK enable.
// Define SPI_CONT_CS_EN to add an active-low slave-select output o_cs_n.
module spi_cont
    import spi_cont_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    spi_cont_if.slave    bus,
    output logic         o_mosi,
    output logic         o_sclk,
`ifdef SPI_CONT_CS_EN
    output logic         o_cs_n,
`endif
    input  logic         i_miso
);

    localparam int                CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sclk;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_last_fall;
    logic                  w_tx_msb;
    logic [DATA_WIDTH-1:0] w_rx;

    // A write is also taken in DONE so transfers can run back to back.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_last_fall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_stb) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_tick) begin
                    if (!r_sclk) begin
                        w_rise = 1'b1;
                    end else begin
                        w_fall = 1'b1;
                        if (r_cnt == LAST) begin
                            w_last_fall = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.wr_stb) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt  <= '0;
                r_sclk <= 1'b0;
            end
            if (w_rise)
                r_sclk <= 1'b1;
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (!w_last_fall)
                    r_cnt <= r_cnt + 1'b1;
            end
            // Last sample happened on the preceding rise, so rx is complete here.
            if (w_last_fall)
                r_rdata <= w_rx;
        end
    end

    spi_cont_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_load_data (bus.wr_data),
        .i_shift     (w_fall && !w_last_fall),
        .i_sample    (w_rise),
        .i_miso      (i_miso),
        .o_tx_msb    (w_tx_msb),
        .o_rx_data   (w_rx)
    );

    assign bus.wr_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign bus.rd_stb   = (r_state == ST_DONE);
    assign bus.rd_data  = r_rdata;
    assign o_mosi       = (r_state == ST_SHIFT) ? w_tx_msb : 1'b0;
    assign o_sclk       = r_sclk;
`ifdef SPI_CONT_CS_EN
    assign o_cs_n       = (r_state == ST_IDLE);
`endif

endmodule

// File: tb/tb_spi_cont.sv
// Directed bench for spi_cont: slave model drives MISO from a bit pattern.
module tb_spi_cont;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic       miso;
    logic       mosi;
    logic       sclk;
`ifdef SPI_CONT_CS_EN
    logic       cs_n;
`endif

    int total = 0;
    int bad   = 0;

    spi_cont_if #(.DATA_WIDTH(8)) bus ();

    spi_cont #(.DATA_WIDTH(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_tick (tick),
        .bus    (bus),
        .o_mosi (mosi),
        .o_sclk (sclk),
`ifdef SPI_CONT_CS_EN
        .o_cs_n (cs_n),
`endif
        .i_miso (miso)
    );

    always #5 clk = ~clk;

    // Half-bit enable every 5 CLKs, free running.
    int tdiv = 0;
    always @(negedge clk) begin
        if (tdiv == 4) begin
            tdiv <= 0;
            tick <= 1'b1;
        end else begin
            tdiv <= tdiv + 1;
            tick <= 1'b0;
        end
    end

    // Slave: bit (idx-base) of pat, MSB first, advanced on each SCLK fall.
    logic [63:0] pat  = '0;
    int          base = 0;
    int          idx  = 0;
    always @(negedge sclk) idx <= idx + 1;
    always_comb begin
        int k;
        k = idx - base;
        miso = (k >= 0 && k < 64) ? pat[6'(63 - k)] : 1'b0;
    end

    int         sclk_pulses = 0;
    logic [7:0] cap = '0;
    int         stb_cnt = 0;
    always @(posedge sclk) begin
        sclk_pulses <= sclk_pulses + 1;
        cap         <= {cap[6:0], mosi};
    end
    always @(posedge clk) if (bus.rd_stb === 1'b1) stb_cnt <= stb_cnt + 1;

    task automatic start_xfer(input logic [7:0] d, input logic [63:0] p, input bit new_pat);
        for (int i = 0; i < 100 && bus.wr_ready !== 1'b1; i++) @(negedge clk);
        if (new_pat) begin
            pat  = p;
            base = idx;
        end
        bus.wr_stb  = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_stb  = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (bus.rd_stb === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.wr_stb  = 1'b0;
        bus.wr_data = '0;
        repeat (10) @(negedge clk);
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.wr_ready); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got %b want 0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got %b want 0", mosi); end
        total++; if (bus.rd_stb !== 1'b0) begin bad++; $display("FAIL reset_rstb got %b want 0", bus.rd_stb); end
        total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rdata got %h want 00", bus.rd_data); end
`ifdef SPI_CONT_CS_EN
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_csn got %b want 1", cs_n); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int p0, s0;
        bit ok;
        p0 = sclk_pulses;
        s0 = stb_cnt;
        start_xfer(8'hAB, {8'h29, 56'h0}, 1'b1);
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL single_busy got %b want 0", bus.wr_ready); end
        total++; if (mosi !== 1'b1) begin bad++; $display("FAIL single_mosi_msb got %b want 1", mosi); end
`ifdef SPI_CONT_CS_EN
        total++; if (cs_n !== 1'b0) begin bad++; $display("FAIL single_csn_act got %b want 0", cs_n); end
`endif
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got 0 want 1"); end
        total++; if (bus.rd_data !== 8'h29) begin bad++; $display("FAIL single_rdata got %h want 29", bus.rd_data); end
        total++; if (cap !== 8'hAB) begin bad++; $display("FAIL single_mosi_bits got %h want ab", cap); end
        total++; if (sclk_pulses - p0 !== 8) begin bad++; $display("FAIL single_pulses got %0d want 8", sclk_pulses - p0); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL single_ready_done got %b want 1", bus.wr_ready); end
`ifdef SPI_CONT_CS_EN
        total++; if (cs_n !== 1'b0) begin bad++; $display("FAIL single_csn_done got %b want 0", cs_n); end
`endif
        @(negedge clk);
        total++; if (bus.rd_stb !== 1'b0) begin bad++; $display("FAIL single_rstb_width got %b want 0", bus.rd_stb); end
        total++; if (stb_cnt - s0 !== 1) begin bad++; $display("FAIL single_rstb_count got %0d want 1", stb_cnt - s0); end
`ifdef SPI_CONT_CS_EN
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL single_csn_idle got %b want 1", cs_n); end
`endif
    endtask

    task automatic test_back_to_back;
        int p0;
        bit ok;
        bit ready_seen;
        start_xfer(8'hAB, {8'h29, 8'h63, 48'h0}, 1'b1);
        wait_done(ok);
        total++; if (!ok || bus.rd_data !== 8'h29) begin bad++; $display("FAIL b2b_first got %h want 29", bus.rd_data); end
        p0 = sclk_pulses;
        bus.wr_stb  = 1'b1;
        bus.wr_data = 8'hAB;
        @(negedge clk);
        bus.wr_stb  = 1'b0;
        total++; if (mosi !== 1'b1) begin bad++; $display("FAIL b2b_mosi_msb got %b want 1", mosi); end
        ready_seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (bus.rd_stb === 1'b1) ok = 1'b1;
            else begin
                if (bus.wr_ready !== 1'b0) ready_seen = 1'b1;
                @(negedge clk);
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got 0 want 1"); end
        total++; if (ready_seen !== 1'b0) begin bad++; $display("FAIL b2b_ready_low got %b want 0", ready_seen); end
        total++; if (bus.rd_data !== 8'h63) begin bad++; $display("FAIL b2b_rdata got %h want 63", bus.rd_data); end
        total++; if (cap !== 8'hAB) begin bad++; $display("FAIL b2b_mosi_bits got %h want ab", cap); end
        total++; if (sclk_pulses - p0 !== 8) begin bad++; $display("FAIL b2b_pulses got %0d want 8", sclk_pulses - p0); end
        @(negedge clk);
    endtask

    task automatic test_ignore_wstb;
        int p0, s0;
        bit ok;
        p0 = sclk_pulses;
        s0 = stb_cnt;
        start_xfer(8'hC3, {8'h5A, 56'h0}, 1'b1);
        repeat (20) @(negedge clk);
        bus.wr_stb  = 1'b1;
        bus.wr_data = 8'hFF;
        @(negedge clk);
        bus.wr_stb  = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout got 0 want 1"); end
        total++; if (bus.rd_data !== 8'h5A) begin bad++; $display("FAIL ign_rdata got %h want 5a", bus.rd_data); end
        total++; if (cap !== 8'hC3) begin bad++; $display("FAIL ign_mosi_bits got %h want c3", cap); end
        repeat (60) @(negedge clk);
        total++; if (stb_cnt - s0 !== 1) begin bad++; $display("FAIL ign_rstb_count got %0d want 1", stb_cnt - s0); end
        total++; if (sclk_pulses - p0 !== 8) begin bad++; $display("FAIL ign_pulses got %0d want 8", sclk_pulses - p0); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL ign_ready got %b want 1", bus.wr_ready); end
    endtask

    task automatic test_reset_mid;
        int p0, s0;
        bit ok;
        p0 = sclk_pulses;
        start_xfer(8'hAB, {8'hFF, 56'h0}, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (sclk_pulses - p0 == 3) ok = 1'b1;
            else @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got 0 want 1"); end
        s0 = stb_cnt;
        rst = 1'b1;
        @(negedge clk);
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rstmid_sclk got %b want 0", sclk); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b want 1", bus.wr_ready); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rstmid_mosi got %b want 0", mosi); end
        total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL rstmid_rdata got %h want 00", bus.rd_data); end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        total++; if (stb_cnt !== s0) begin bad++; $display("FAIL rstmid_no_rstb got %0d want %0d", stb_cnt, s0); end
        start_xfer(8'h96, {8'h3C, 56'h0}, 1'b1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_new_timeout got 0 want 1"); end
        total++; if (bus.rd_data !== 8'h3C) begin bad++; $display("FAIL rstmid_new_rdata got %h want 3c", bus.rd_data); end
        total++; if (cap !== 8'h96) begin bad++; $display("FAIL rstmid_new_mosi got %h want 96", cap); end
        @(negedge clk);
    endtask

    initial begin
        bus.wr_stb  = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_wstb();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cont.md
# spi_cont

SPI master byte controller (mode 0, MSB first) between an internal register/command bus and an external SPI slave. Accepts a write strobe with a data word, shifts it out on MOSI while shifting in MISO, then presents the received word with a one-cycle strobe. Bit rate is set by an external clock-enable pulse (TICK) from a shared divider; each TICK is one SCLK half-period.

## Interface
- DATA_WIDTH, 8: bits per transfer; bit-counter width is clog2(DATA_WIDTH).
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- TICK  in  1  one-CLK-wide half-bit enable; ignored while idle.
- W_STB  in  1  write request; accepted only when W_READY=1.
- W_DATA  in  DATA_WIDTH  word to transmit, sampled on the W_STB cycle.
- W_READY  out  1  high when idle and able to accept W_STB.
- R_STB  out  1  one-CLK pulse: transfer complete, R_DATA valid.
- R_DATA  out  DATA_WIDTH  last received word, held until next completion.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- SCLK  out  1  SPI clock, idle low.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: W_READY=1, SCLK=0, MOSI=0. W_STB=1 → load tx shift reg with W_DATA, MOSI=W_DATA[MSB], clear bit counter, clear rx reg, go SHIFT.
- SHIFT, on TICK with SCLK=0: SCLK←1, rx←{rx[DATA_WIDTH-2:0], MISO} (sample on rising edge).
- SHIFT, on TICK with SCLK=1: SCLK←0; if bit counter = DATA_WIDTH-1 go DONE, else counter+1 and tx shifts left, MOSI←next bit (change on falling edge).
- DONE (one CLK): R_DATA←rx, R_STB=1, go IDLE.
- W_STB while not IDLE: ignored, no queueing.
- TICK in IDLE or DONE: no effect.
- MISO sampled without synchronizer; slave must meet setup to rising SCLK.

## Timing
- Reset values: W_READY=1, R_STB=0, R_DATA=0, MOSI=0, SCLK=0, state IDLE, counters 0.
- W_STB accepted at edge N → W_READY=0 and MOSI valid from N+1.
- First SCLK rise at first TICK after acceptance (MOSI setup ≥1 CLK).
- A transfer spans 2·DATA_WIDTH TICKs; final SCLK fall on the 2·DATA_WIDTH-th TICK.
- R_STB high the CLK after final fall; W_READY returns high in that same cycle; W_STB in that cycle is accepted (back-to-back).
- RST mid-transfer: abort immediately, reset values, no R_STB.

## Configuration
- SPI_CONT_CS_EN defined: extra output CS_N (1 bit, reset 1) driven 0 from acceptance cycle+1 through DONE, 1 in IDLE.
- Undefined: no CS_N port; slave select handled externally. All other behaviour identical.

## Structure
- Package spi_cont_pkg: state enum (IDLE, SHIFT, DONE), default DATA_WIDTH constant.
- One sub-module natural: spi_cont_shifter (parallel-load tx shift reg + rx shift reg, shift/sample enables from FSM). Bit counter and FSM stay in top.

## Test plan
- Reset: RST high 10 CLKs → W_READY=1, SCLK=0, MOSI=0, R_STB=0, R_DATA=0x00.
- TICK every 5 CLKs, W_STB with W_DATA=0xAB, slave shifts 0x29 MSB first on SCLK falling → MOSI on rising edges reads 1,0,1,0,1,0,1,1; exactly 8 SCLK pulses; R_STB one cycle; R_DATA=0x29.
- Second W_STB 0xAB on cycle after R_STB, slave continues with 0x63 → R_DATA=0x63, no gap bits, W_READY low throughout.
- W_STB=0xFF mid-transfer → ignored; current transfer completes unchanged, no second R_STB.
- RST asserted after 3 SCLK pulses → SCLK=0, W_READY=1 next cycle, no R_STB; new transfer afterwards completes correctly.
- SPI_CONT_CS_EN defined → CS_N=1 idle, 0 for whole transfer, 1 cycle after R_STB.
